// File: rtl/spectrum_peak_scan_if.sv
// Magnitude capture, scan configuration and peak record stream of spectrum_peak_scan.
// The slave modport is the block's own view; master is the environment's.
interface spectrum_peak_scan_if #(
  parameter int ADDR_W = 13,
  parameter int MAG_W  = 16,
  parameter int DROP_W = 8
);
  logic [ADDR_W-1:0] s_mag_addr;
  logic [MAG_W-1:0]  s_mag_data;
  logic              s_mag_valid;
  logic              s_mag_last;
  logic [MAG_W-1:0]  s_cfg_thresh;
  logic [ADDR_W-1:0] s_cfg_bin_lo;
  logic [ADDR_W-1:0] s_cfg_bin_hi;
  logic [ADDR_W-1:0] m_peak_addr;
  logic [MAG_W-1:0]  m_peak_data;
  logic [2:0]        m_peak_rank;
  logic              m_peak_valid;
  logic              m_peak_ready;
  logic              m_peak_last;
  logic              m_busy;
  logic [DROP_W-1:0] m_drop_cnt;

  modport master (
    output s_mag_addr, s_mag_data, s_mag_valid, s_mag_last,
    output s_cfg_thresh, s_cfg_bin_lo, s_cfg_bin_hi, m_peak_ready,
    input  m_peak_addr, m_peak_data, m_peak_rank, m_peak_valid, m_peak_last,
    input  m_busy, m_drop_cnt
  );

  modport slave (
    input  s_mag_addr, s_mag_data, s_mag_valid, s_mag_last,
    input  s_cfg_thresh, s_cfg_bin_lo, s_cfg_bin_hi, m_peak_ready,
    output m_peak_addr, m_peak_data, m_peak_rank, m_peak_valid, m_peak_last,
    output m_busy, m_drop_cnt
  );
endinterface

// File: rtl/spectrum_peak_scan.sv
// Ping-pong FFT magnitude buffer with a windowed local-maximum scan that keeps the
// NPEAK largest peaks and streams them largest first; capture overlaps scan/emit.
module spectrum_peak_scan #(
  parameter int ADDR_W = 13,
  parameter int MAG_W  = 16,
  parameter int NPEAK  = 4,
  parameter int DROP_W = 8
) (
  input logic                 sys_clk,
  input logic                 sys_rstn,
  spectrum_peak_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam int         CNT_W     = ADDR_W + 2;
  localparam logic [2:0] LAST_RANK = 3'(NPEAK - 1);

  state_t state, state_nx;

  logic              wb;
  logic [MAG_W-1:0]  mem [2*DEPTH];
  logic [ADDR_W-1:0] lo_r, hi_r;
  logic [MAG_W-1:0]  thresh_r;
  logic [CNT_W-1:0]  cyc, span;
  logic [ADDR_W-1:0] rd_addr, rd_bin, w2_bin, w1_bin;
  logic [MAG_W-1:0]  rd_data, w0_data, w1_data, w2_data;
  logic              rd_vld;
  logic [2:0]        w_vld;
  logic              frame_end, issue, scan_done, xfer, cand_ok;

  logic [ADDR_W-1:0] tbl_addr [NPEAK];
  logic [MAG_W-1:0]  tbl_data [NPEAK];
  logic [NPEAK-1:0]  tbl_full;
  logic [ADDR_W-1:0] nx_addr [NPEAK];
  logic [MAG_W-1:0]  nx_data [NPEAK];
  logic [NPEAK-1:0]  nx_full;
  logic [ADDR_W-1:0] prev_addr;
  logic [MAG_W-1:0]  prev_data;
  logic              prev_full, seen, hit;

  logic [ADDR_W-1:0] peak_addr;
  logic [MAG_W-1:0]  peak_data;
  logic [2:0]        peak_rank;
  logic              peak_valid, peak_last;
  logic [DROP_W-1:0] drop_cnt;

  assign frame_end = bus.s_mag_valid & bus.s_mag_last;
  assign span      = (hi_r > lo_r) ? CNT_W'(hi_r - lo_r) : '0;
  assign issue     = (cyc <= span);
  assign scan_done = (cyc == span + CNT_W'(3));
  assign rd_addr   = lo_r + cyc[ADDR_W-1:0];
  assign xfer      = peak_valid & bus.m_peak_ready;
  // w0/w1/w2 are m[i-1]/m[i]/m[i+1]; requiring all three valid keeps lo and hi out of candidacy.
  assign cand_ok   = (state == SCAN) && (&w_vld) && (w1_data > w0_data) &&
                     (w1_data >= w2_data) && (w1_data >= thresh_r);

  // NOTE: the bank RAM has no reset so it maps onto block RAM; its contents are don't-care after reset.
  always_ff @(posedge sys_clk) begin
    if (bus.s_mag_valid) mem[{wb, bus.s_mag_addr}] <= bus.s_mag_data;
    rd_data <= mem[{~wb, rd_addr}];
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) state <= IDLE;
    else           state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_end) state_nx = SCAN;
      SCAN:    if (scan_done) state_nx = EMIT;
      EMIT:    if (xfer && peak_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sorted insertion: the first slot that is empty or strictly smaller takes the
  // candidate and every later slot takes its predecessor's old contents.
  always_comb begin
    seen      = 1'b0;
    hit       = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    prev_full = 1'b0;
    nx_full   = tbl_full;
    for (int k = 0; k < NPEAK; k++) begin
      nx_addr[k] = tbl_addr[k];
      nx_data[k] = tbl_data[k];
      hit        = ~tbl_full[k] | (tbl_data[k] < w1_data);
      if (cand_ok && seen) begin
        nx_addr[k] = prev_addr;
        nx_data[k] = prev_data;
        nx_full[k] = prev_full;
      end else if (cand_ok && hit) begin
        nx_addr[k] = w1_bin;
        nx_data[k] = w1_data;
        nx_full[k] = 1'b1;
      end
      seen      = seen | hit;
      prev_addr = tbl_addr[k];
      prev_data = tbl_data[k];
      prev_full = tbl_full[k];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wb       <= 1'b0;
      lo_r     <= '0;
      hi_r     <= '0;
      thresh_r <= '0;
      cyc      <= '0;
      rd_vld   <= 1'b0;
      rd_bin   <= '0;
      w_vld    <= '0;
      w0_data  <= '0;
      w1_data  <= '0;
      w2_data  <= '0;
      w1_bin   <= '0;
      w2_bin   <= '0;
      tbl_full <= '0;
      for (int k = 0; k < NPEAK; k++) begin
        tbl_addr[k] <= '0;
        tbl_data[k] <= '0;
      end
    end else if (state == IDLE && frame_end) begin
      wb       <= ~wb;
      lo_r     <= bus.s_cfg_bin_lo;
      hi_r     <= bus.s_cfg_bin_hi;
      thresh_r <= bus.s_cfg_thresh;
      cyc      <= '0;
      rd_vld   <= 1'b0;
      w_vld    <= '0;
      tbl_full <= '0;
      for (int k = 0; k < NPEAK; k++) begin
        tbl_addr[k] <= '0;
        tbl_data[k] <= '0;
      end
    end else if (state == SCAN) begin
      cyc      <= cyc + CNT_W'(1);
      rd_vld   <= issue;
      rd_bin   <= rd_addr;
      w_vld    <= {rd_vld, w_vld[2:1]};
      w0_data  <= w1_data;
      w1_data  <= w2_data;
      w2_data  <= rd_data;
      w1_bin   <= w2_bin;
      w2_bin   <= rd_bin;
      tbl_addr <= nx_addr;
      tbl_data <= nx_data;
      tbl_full <= nx_full;
    end
  end

  // Empty slots already hold addr 0 / data 0, so records are taken straight from the table.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      peak_valid <= 1'b0;
      peak_addr  <= '0;
      peak_data  <= '0;
      peak_rank  <= '0;
      peak_last  <= 1'b0;
    end else if (state == SCAN && scan_done) begin
      peak_valid <= 1'b1;
      peak_addr  <= tbl_addr[0];
      peak_data  <= tbl_data[0];
      peak_rank  <= '0;
      peak_last  <= (LAST_RANK == 3'd0);
    end else if (state == EMIT && xfer) begin
      if (peak_last) begin
        peak_valid <= 1'b0;
        peak_addr  <= '0;
        peak_data  <= '0;
        peak_rank  <= '0;
        peak_last  <= 1'b0;
      end else begin
        for (int k = 1; k < NPEAK; k++) begin
          if (int'(peak_rank) + 1 == k) begin
            peak_addr <= tbl_addr[k];
            peak_data <= tbl_data[k];
          end
        end
        peak_rank <= peak_rank + 3'd1;
        peak_last <= (peak_rank + 3'd1) == LAST_RANK;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)                                        drop_cnt <= '0;
    else if (frame_end && state != IDLE && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
  end

  assign bus.m_peak_addr  = peak_addr;
  assign bus.m_peak_data  = peak_data;
  assign bus.m_peak_rank  = peak_rank;
  assign bus.m_peak_valid = peak_valid;
  assign bus.m_peak_last  = peak_last;
  assign bus.m_busy       = (state != IDLE);
  assign bus.m_drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_spectrum_peak_scan.sv
// Scoreboard bench for spectrum_peak_scan: a reference peak picker fills the expected
// record queue per frame and records are popped as the DUT transfers them.
module tb_spectrum_peak_scan;
  localparam int ADDR_W = 13;
  localparam int MAG_W  = 16;
  localparam int NPEAK  = 4;
  localparam int DROP_W = 8;
  localparam int LIMIT  = 2000;

  logic sys_clk  = 1'b0;
  logic sys_rstn = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spectrum_peak_scan_if #(.ADDR_W(ADDR_W), .MAG_W(MAG_W), .DROP_W(DROP_W)) bus ();

  spectrum_peak_scan #(.ADDR_W(ADDR_W), .MAG_W(MAG_W), .NPEAK(NPEAK), .DROP_W(DROP_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .bus      (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [MAG_W-1:0]  data;
    logic [2:0]        rank;
    logic              last;
  } rec_t;

  rec_t             sb_q [$];
  logic [MAG_W-1:0] tb_mag [32];
  int               checks   = 0;
  int               errors   = 0;
  int               exp_drop = 0;

  function automatic bit is_peak(input int i, input int th);
    return (tb_mag[i] > tb_mag[i-1]) && (tb_mag[i] >= tb_mag[i+1]) && (int'(tb_mag[i]) >= th);
  endfunction

  // Reference: repeatedly pick the largest unused peak, earliest bin on ties.
  task automatic push_expected(input int lo, input int hi, input int th);
    bit   used [32];
    int   best;
    rec_t r;
    for (int i = 0; i < 32; i++) used[i] = 1'b0;
    for (int k = 0; k < NPEAK; k++) begin
      best = -1;
      for (int i = lo + 1; i < hi; i++)
        if (is_peak(i, th) && !used[i] && (best < 0 || tb_mag[i] > tb_mag[best])) best = i;
      r.rank = 3'(k);
      r.last = (k == NPEAK - 1);
      if (best >= 0) begin
        used[best] = 1'b1;
        r.addr = ADDR_W'(best);
        r.data = tb_mag[best];
      end else begin
        r.addr = '0;
        r.data = '0;
      end
      sb_q.push_back(r);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 32; i++) tb_mag[i] = MAG_W'(v);
  endtask

  // Writes bins 0..31 and returns 1 ns after the edge that captures the frame end.
  task automatic send_frame(input int lo, input int hi, input int th);
    bus.s_cfg_bin_lo = ADDR_W'(lo);
    bus.s_cfg_bin_hi = ADDR_W'(hi);
    bus.s_cfg_thresh = MAG_W'(th);
    for (int b = 0; b < 32; b++) begin
      @(posedge sys_clk); #1;
      bus.s_mag_valid = 1'b1;
      bus.s_mag_addr  = ADDR_W'(b);
      bus.s_mag_data  = tb_mag[b];
      bus.s_mag_last  = (b == 31);
    end
    push_expected(lo, hi, th);
    @(posedge sys_clk); #1;
    bus.s_mag_valid = 1'b0;
    bus.s_mag_last  = 1'b0;
  endtask

  task automatic pulse_frame_end();
    @(posedge sys_clk); #1;
    bus.s_mag_valid = 1'b1;
    bus.s_mag_last  = 1'b1;
    bus.s_mag_addr  = '0;
    bus.s_mag_data  = '0;
    @(posedge sys_clk); #1;
    bus.s_mag_valid = 1'b0;
    bus.s_mag_last  = 1'b0;
  endtask

  // Counts negedges until m_peak_valid; LIMIT means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge sys_clk);
    while (!bus.m_peak_valid && lat < LIMIT) begin
      lat++;
      @(negedge sys_clk);
    end
  endtask

  // mode 0: ready held high; mode 1: ready low 10 cycles on rank 1, then random.
  task automatic collect(input int exp_lat, input int mode, input bit drop_at_end);
    int   lat, n, n0, stall, guard;
    bit   pulse;
    rec_t e;
    if (mode == 0 || mode == 1) bus.m_peak_ready = 1'b1;
    n0 = sb_q.size();
    wait_valid(lat);
    checks++;
    if (lat >= LIMIT) begin
      errors++;
      $display("FAIL first_valid: no record within %0d cycles", LIMIT);
      sb_q.delete();
      return;
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL scan_latency: got %0d cycles, expected %0d", lat, exp_lat);
      end
    end
    n = 0; stall = 0; guard = 0;
    while (sb_q.size() > 0 && guard < LIMIT) begin
      guard++;
      pulse = 1'b0;
      if (bus.m_peak_valid && bus.m_peak_ready) begin
        e = sb_q.pop_front();
        n++;
        checks++;
        if ({bus.m_peak_addr, bus.m_peak_data, bus.m_peak_rank, bus.m_peak_last} !==
            {e.addr, e.data, e.rank, e.last}) begin
          errors++;
          $display("FAIL record: got addr=%0d data=%0d rank=%0d last=%0b, expected addr=%0d data=%0d rank=%0d last=%0b",
                   bus.m_peak_addr, bus.m_peak_data, bus.m_peak_rank, bus.m_peak_last,
                   e.addr, e.data, e.rank, e.last);
        end
        if (drop_at_end && e.last) begin
          bus.s_mag_valid = 1'b1;
          bus.s_mag_last  = 1'b1;
          bus.s_mag_addr  = '0;
          bus.s_mag_data  = '0;
          pulse = 1'b1;
        end
      end else if (bus.m_peak_valid) begin
        e = sb_q[0];
        checks++;
        if ({bus.m_peak_addr, bus.m_peak_data, bus.m_peak_rank, bus.m_peak_last} !==
            {e.addr, e.data, e.rank, e.last}) begin
          errors++;
          $display("FAIL hold_stable: got addr=%0d data=%0d rank=%0d, expected addr=%0d data=%0d rank=%0d",
                   bus.m_peak_addr, bus.m_peak_data, bus.m_peak_rank, e.addr, e.data, e.rank);
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL valid_dropped: valid low with %0d records pending", sb_q.size());
        sb_q.delete();
      end
      @(posedge sys_clk); #1;
      if (pulse) begin
        bus.s_mag_valid = 1'b0;
        bus.s_mag_last  = 1'b0;
        if (exp_drop < (1 << DROP_W) - 1) exp_drop++;
      end
      if (mode == 1) begin
        if (bus.m_peak_valid && bus.m_peak_rank == 3'd1 && stall < 10) begin
          bus.m_peak_ready = 1'b0;
          stall++;
        end else if (stall >= 10) begin
          bus.m_peak_ready = 1'($urandom_range(0, 1));
        end else begin
          bus.m_peak_ready = 1'b1;
        end
      end
      @(negedge sys_clk);
    end
    if (guard >= LIMIT) begin
      errors++;
      $display("FAIL emit_timeout: %0d records never transferred", sb_q.size());
      sb_q.delete();
    end
    checks++;
    if (n !== n0) begin
      errors++;
      $display("FAIL transfer_count: got %0d, expected %0d", n, n0);
    end
    checks++;
    if (bus.m_peak_valid !== 1'b0 || bus.m_busy !== 1'b0) begin
      errors++;
      $display("FAIL emit_end: valid=%0b busy=%0b, expected both 0", bus.m_peak_valid, bus.m_busy);
    end
    if (drop_at_end) begin
      checks++;
      if (bus.m_drop_cnt !== DROP_W'(exp_drop)) begin
        errors++;
        $display("FAIL drop_on_last: drop_cnt=%0d, expected %0d", bus.m_drop_cnt, exp_drop);
      end
    end
    bus.m_peak_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({bus.m_peak_valid, bus.m_peak_last, bus.m_busy} !== 3'b000 || bus.m_drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%0b last=%0b busy=%0b drop=%0d, expected all 0",
               bus.m_peak_valid, bus.m_peak_last, bus.m_busy, bus.m_drop_cnt);
    end
    checks++;
    if (bus.m_peak_addr !== '0 || bus.m_peak_data !== '0 || bus.m_peak_rank !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d data=%0d rank=%0d, expected 0",
               bus.m_peak_addr, bus.m_peak_data, bus.m_peak_rank);
    end
    @(posedge sys_clk); #1;
    sys_rstn = 1'b1;
  endtask

  task automatic test_single_peak();
    fill(1);
    tb_mag[5] = 100;
    send_frame(0, 15, 10);
    collect(19, 0, 1'b0);
  endtask

  task automatic test_ordering();
    fill(0);
    tb_mag[3] = 50; tb_mag[7] = 90; tb_mag[11] = 70; tb_mag[14] = 20; tb_mag[20] = 80;
    send_frame(0, 31, 0);
    collect(35, 0, 1'b0);
  endtask

  task automatic test_ties_plateau();
    fill(0);
    tb_mag[4] = 60; tb_mag[5] = 60; tb_mag[9] = 60;
    send_frame(0, 31, 0);
    collect(35, 0, 1'b0);
  endtask

  task automatic test_edge_threshold();
    fill(0);
    tb_mag[2] = 200; tb_mag[12] = 200; tb_mag[7] = 30;
    send_frame(2, 12, 40);
    collect(14, 0, 1'b0);
    fill(0);
    tb_mag[6] = 10; tb_mag[7] = 90; tb_mag[8] = 5;
    send_frame(6, 7, 0);
    collect(5, 0, 1'b0);
  endtask

  task automatic test_overrun();
    fill(2);
    tb_mag[10] = 40;
    send_frame(0, 31, 0);
    pulse_frame_end();
    exp_drop++;
    checks++;
    if (bus.m_drop_cnt !== DROP_W'(exp_drop) || bus.m_busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop: drop_cnt=%0d busy=%0b, expected %0d and 1",
               bus.m_drop_cnt, bus.m_busy, exp_drop);
    end
    collect(-1, 0, 1'b0);
    fill(3);
    tb_mag[17] = 77; tb_mag[25] = 66;
    send_frame(1, 30, 5);
    collect(33, 0, 1'b0);
  endtask

  task automatic test_drop_on_final_transfer();
    fill(0);
    tb_mag[8] = 33; tb_mag[21] = 44;
    send_frame(0, 31, 0);
    collect(35, 0, 1'b1);
    repeat (6) @(negedge sys_clk);
    checks++;
    if (bus.m_busy !== 1'b0 || bus.m_peak_valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_not_scanned: busy=%0b valid=%0b, expected 0", bus.m_busy, bus.m_peak_valid);
    end
  endtask

  task automatic test_backpressure();
    fill(0);
    tb_mag[3] = 50; tb_mag[7] = 90; tb_mag[11] = 70; tb_mag[20] = 80;
    send_frame(0, 31, 0);
    collect(35, 1, 1'b0);
  endtask

  task automatic test_random();
    int lo, hi, th;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) tb_mag[i] = MAG_W'($urandom_range(0, 200));
      lo = $urandom_range(0, 8);
      hi = $urandom_range(lo, 31);
      th = $urandom_range(0, 150);
      send_frame(lo, hi, th);
      collect(hi - lo + 4, 0, 1'b0);
    end
  endtask

  task automatic test_saturate();
    int lat;
    fill(0);
    tb_mag[12] = 9;
    bus.m_peak_ready = 1'b0;
    send_frame(0, 31, 0);
    wait_valid(lat);
    checks++;
    if (lat !== 35) begin
      errors++;
      $display("FAIL sat_latency: got %0d cycles, expected 35", lat);
    end
    @(posedge sys_clk); #1;
    bus.s_mag_valid = 1'b1;
    bus.s_mag_last  = 1'b1;
    repeat (300) @(posedge sys_clk);
    #1;
    bus.s_mag_valid = 1'b0;
    bus.s_mag_last  = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    checks++;
    if (bus.m_drop_cnt !== DROP_W'(exp_drop)) begin
      errors++;
      $display("FAIL drop_saturate: drop_cnt=%0d, expected %0d", bus.m_drop_cnt, exp_drop);
    end
    collect(-1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_emit();
    int lat;
    bit seen_valid;
    fill(0);
    tb_mag[5] = 100;
    bus.m_peak_ready = 1'b0;
    send_frame(0, 15, 10);
    wait_valid(lat);
    checks++;
    if (lat !== 19) begin
      errors++;
      $display("FAIL rst_latency: got %0d cycles, expected 19", lat);
    end
    #2;
    sys_rstn = 1'b0;
    #1;
    checks++;
    if (bus.m_peak_valid !== 1'b0 || bus.m_busy !== 1'b0 || bus.m_drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_emit: valid=%0b busy=%0b drop=%0d, expected all 0",
               bus.m_peak_valid, bus.m_busy, bus.m_drop_cnt);
    end
    sb_q.delete();
    exp_drop = 0;
    bus.m_peak_ready = 1'b1;
    @(posedge sys_clk); #1;
    sys_rstn = 1'b1;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      if (bus.m_peak_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_partial_output: valid seen after reset abort");
    end
    fill(1);
    tb_mag[9] = 120;
    send_frame(0, 15, 10);
    collect(19, 0, 1'b0);
  endtask

  initial begin
    bus.s_mag_addr   = '0;
    bus.s_mag_data   = '0;
    bus.s_mag_valid  = 1'b0;
    bus.s_mag_last   = 1'b0;
    bus.s_cfg_thresh = '0;
    bus.s_cfg_bin_lo = '0;
    bus.s_cfg_bin_hi = '0;
    bus.m_peak_ready = 1'b1;
    test_reset();
    test_single_peak();
    test_ordering();
    test_ties_plateau();
    test_edge_threshold();
    test_overrun();
    test_drop_on_final_transfer();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
